// File: rtl/ipf_pkg.sv
// Shared types and constants for the image-filter LCU feeder.
package ipf_pkg;

    localparam int FRAME_W = 128;
    localparam int ADDR_W  = 14;

    localparam logic [1:0] SIZE_16 = 2'd0;
    localparam logic [1:0] SIZE_32 = 2'd1;
    localparam logic [1:0] SIZE_64 = 2'd2;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  band_pos;
        logic        wo_class;
        logic [15:0] offset;
    } ipf_param_t;

    localparam int ENT_W = 15;

    typedef struct packed {
        logic [7:0] pix;
        logic       first;
        logic [2:0] lx;
        logic [2:0] ly;
    } ipf_ent_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ipf_state_t;

    function automatic logic [5:0] pix_last(input logic [1:0] size);
        case (size)
            SIZE_16: return 6'd15;
            SIZE_32: return 6'd31;
            default: return 6'd63;
        endcase
    endfunction

    function automatic logic [2:0] lcu_last(input logic [1:0] size);
        case (size)
            SIZE_16: return 3'd7;
            SIZE_32: return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/ipf_pix_skid.sv
// Two-entry FIFO holding fetched pixels and their LCU tags until the output stage takes them.
module ipf_pix_skid
    import ipf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [ENT_W-1:0] wr_ent,
    output logic [ENT_W-1:0] rd_ent,
    output logic [1:0]       occ
);

    logic [ENT_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_ent;
    end

    assign rd_ent = mem[rd_ptr];

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Streams a 128x128 frame in LCU order into the filter, with per-LCU parameters aligned to din.
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing image/parameter reads
// DRAIN | all reads issued, emptying the pipeline
module ipf_lcu_feeder
    import ipf_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cfg_lcu_size,
    output logic        img_rd,
    output logic [13:0] img_addr,
    input  logic [7:0]  img_data,
    output logic        prm_rd,
    output logic [5:0]  prm_addr,
    input  logic [23:0] prm_data,
    input  logic        busy,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  ipf_type,
    output logic [4:0]  ipf_band_pos,
    output logic        ipf_wo_class,
    output logic [15:0] ipf_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    output logic        active,
    output logic        done
);

    ipf_state_t state, state_nxt;
    logic [5:0] pix_i, pix_j;
    logic [2:0] cur_lx, cur_ly;
    logic       issue, done_nxt, last_pos;
    logic       rd_vld, rd_first;
    logic [2:0] rd_lx, rd_ly;
    logic [1:0] occ, fill;
    logic       out_free, from_skid, bypass, push, pop;
    logic [6:0] pos_x, pos_y;
    logic [ENT_W-1:0] head_raw;
    ipf_ent_t   head, in_ent, src;
    ipf_param_t shadow, prm_in, par_src;

    assign prm_in   = ipf_param_t'(prm_data);
    assign head     = ipf_ent_t'(head_raw);
    assign in_ent   = ipf_ent_t'({img_data, rd_first, rd_lx, rd_ly});
    assign last_pos = pix_i == pix_last(lcu_size) && pix_j == pix_last(lcu_size) &&
                      cur_lx == lcu_last(lcu_size) && cur_ly == lcu_last(lcu_size);

    // Occupancy plus the read in flight; capping this at 1 keeps the skid from overflowing.
    assign fill      = occ + 2'(rd_vld);
    assign out_free  = !in_en || !busy;
    assign from_skid = out_free && occ != 2'd0;
    assign bypass    = out_free && occ == 2'd0 && rd_vld;
    assign push      = rd_vld && !bypass;
    assign pop       = from_skid;
    assign src       = from_skid ? head : in_ent;
    assign par_src   = from_skid ? shadow : prm_in;
    assign active    = state != IDLE;
    assign img_rd    = issue;
    assign prm_rd    = issue && pix_i == 6'd0 && pix_j == 6'd0;

    always_comb begin
        pos_x    = '0;
        pos_y    = '0;
        prm_addr = '0;
        case (lcu_size)
            SIZE_16: begin
                pos_x    = {cur_lx, pix_i[3:0]};
                pos_y    = {cur_ly, pix_j[3:0]};
                prm_addr = {cur_ly, cur_lx};
            end
            SIZE_32: begin
                pos_x    = {cur_lx[1:0], pix_i[4:0]};
                pos_y    = {cur_ly[1:0], pix_j[4:0]};
                prm_addr = {2'b0, cur_ly[1:0], cur_lx[1:0]};
            end
            default: begin
                pos_x    = {cur_lx[0], pix_i};
                pos_y    = {cur_ly[0], pix_j};
                prm_addr = {4'b0, cur_ly[0], cur_lx[0]};
            end
        endcase
        img_addr = ADDR_W'(pos_y) * ADDR_W'(FRAME_W) + ADDR_W'(pos_x);
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                issue = fill <= 2'd1;
                if (issue && last_pos) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (occ == 2'd0 && !rd_vld && out_free) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            lcu_size <= 2'd0;
            pix_i    <= '0;
            pix_j    <= '0;
            cur_lx   <= '0;
            cur_ly   <= '0;
            rd_vld   <= 1'b0;
            rd_first <= 1'b0;
            rd_lx    <= '0;
            rd_ly    <= '0;
            shadow   <= '0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            rd_vld   <= issue;
            rd_first <= prm_rd;
            rd_lx    <= cur_lx;
            rd_ly    <= cur_ly;
            if (rd_first) shadow <= prm_in;
            if (state == IDLE && start) begin
                lcu_size <= (cfg_lcu_size == 2'd3) ? SIZE_64 : cfg_lcu_size;
                pix_i    <= '0;
                pix_j    <= '0;
                cur_lx   <= '0;
                cur_ly   <= '0;
            end else if (issue) begin
                if (pix_i != pix_last(lcu_size)) pix_i <= pix_i + 6'd1;
                else begin
                    pix_i <= '0;
                    if (pix_j != pix_last(lcu_size)) pix_j <= pix_j + 6'd1;
                    else begin
                        pix_j <= '0;
                        if (cur_lx != lcu_last(lcu_size)) cur_lx <= cur_lx + 3'd1;
                        else begin
                            cur_lx <= '0;
                            cur_ly <= (cur_ly == lcu_last(lcu_size)) ? 3'd0 : cur_ly + 3'd1;
                        end
                    end
                end
            end
        end
    end

    // Parameters follow the first pixel of an LCU into the output stage, so they switch with din.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_en        <= 1'b0;
            din          <= '0;
            ipf_type     <= '0;
            ipf_band_pos <= '0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= '0;
            lcu_x        <= '0;
            lcu_y        <= '0;
        end else if (out_free) begin
            if (from_skid || bypass) begin
                in_en <= 1'b1;
                din   <= src.pix;
                if (src.first) begin
                    ipf_type     <= par_src.typ;
                    ipf_band_pos <= par_src.band_pos;
                    ipf_wo_class <= par_src.wo_class;
                    ipf_offset   <= par_src.offset;
                    lcu_x        <= src.lx;
                    lcu_y        <= src.ly;
                end
            end else begin
                in_en <= 1'b0;
            end
        end
    end

    ipf_pix_skid u_skid (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_ent (in_ent),
        .rd_ent (head_raw),
        .occ    (occ)
    );

endmodule
